// File: rtl/imm_extend_pkg.sv
// Shared types and immediate formatting helpers for the RV32I immediate generator.
// IMM_EXTEND_UTYPE_EN (see imm_extend_comb / imm_extend_unit) adds the U-type override.
package imm_extend_pkg;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned SRC_W  = 25;
   localparam int unsigned CTRL_W = 2;

   typedef enum logic [CTRL_W-1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_fmt_e;

   // src[k] holds instr[k+7]; src[24] is the sign bit for every signed format
   function automatic logic [XLEN-1:0] build_imm(input logic [SRC_W-1:0] src,
                                                 input imm_fmt_e         fmt);
      logic            s;
      logic [XLEN-1:0] imm;
      s   = src[24];
      imm = '0;
      case (fmt)
         IMM_I:   imm = {{20{s}}, src[24:13]};
         IMM_S:   imm = {{20{s}}, src[24:18], src[4:0]};
         IMM_B:   imm = {{19{s}}, src[24], src[0], src[23:18], src[4:1], 1'b0};
         IMM_J:   imm = {{11{s}}, src[24], src[12:5], src[13], src[23:14], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

   // Upper immediate: instr[31:12] in place, low 12 bits zero
   function automatic logic [XLEN-1:0] build_uimm(input logic [SRC_W-1:0] src);
      return {src[24:5], 12'b0};
   endfunction

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational immediate formatter; with IMM_EXTEND_UTYPE_EN defined a utype_sel_i
// input overrides the format select and produces the U-type immediate.
module imm_extend_comb
   import imm_extend_pkg::*;
(
   input  logic [SRC_W-1:0]  src_i,
   input  logic [CTRL_W-1:0] fmt_i,
`ifdef IMM_EXTEND_UTYPE_EN
   input  logic              utype_sel_i,
`endif
   output logic [XLEN-1:0]   imm_o
);

   logic [XLEN-1:0] signed_imm;

   always_comb begin
      signed_imm = build_imm(src_i, imm_fmt_e'(fmt_i));
   end

`ifdef IMM_EXTEND_UTYPE_EN
   always_comb begin
      imm_o = signed_imm;
      if (utype_sel_i) begin
         imm_o = build_uimm(src_i);
      end
   end
`else
   assign imm_o = signed_imm;
`endif

endmodule

// File: rtl/imm_extend_unit.sv
// Decode-stage RV32I immediate generator: combinational immediate plus a one-cycle
// registered copy with valid flag. IMM_EXTEND_UTYPE_EN adds the utype_sel input.
module imm_extend_unit #(
   parameter int unsigned     XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_IMM = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [24:0]     src,
   input  logic [1:0]      control,
`ifdef IMM_EXTEND_UTYPE_EN
   input  logic            utype_sel,
`endif
   output logic [XLEN-1:0] extend_src,
   output logic            out_valid,
   output logic [XLEN-1:0] imm_comb
);

   import imm_extend_pkg::*;

   logic [XLEN-1:0] imm_c;
   logic [XLEN-1:0] extend_d, extend_q;
   logic            valid_d,  valid_q;

   imm_extend_comb u_comb (
      .src_i       (src),
      .fmt_i       (control),
`ifdef IMM_EXTEND_UTYPE_EN
      .utype_sel_i (utype_sel),
`endif
      .imm_o       (imm_c)
   );

   // Capture on valid, otherwise hold the last result and drop the flag
   always_comb begin
      extend_d = extend_q;
      valid_d  = in_valid;
      if (in_valid) begin
         extend_d = imm_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         extend_q <= RESET_IMM;
         valid_q  <= 1'b0;
      end else begin
         extend_q <= extend_d;
         valid_q  <= valid_d;
      end
   end

   assign imm_comb   = imm_c;
   assign extend_src = extend_q;
   assign out_valid  = valid_q;

`ifndef SYNTHESIS
   logic utype_active;
`ifdef IMM_EXTEND_UTYPE_EN
   assign utype_active = utype_sel;
`else
   assign utype_active = 1'b0;
`endif

   // Simulation-only sanity checks on the accepted input
   always_ff @(posedge clk) begin
      if (rst_n && in_valid) begin
         assert (!$isunknown(control))
            else $error("imm_extend_unit: control is X/Z while in_valid=1");
         if (!utype_active && !$isunknown(control) && control[1]) begin
            assert (imm_c[0] == 1'b0)
               else $error("imm_extend_unit: B/J immediate has bit 0 set");
         end
      end
   end
`endif

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed + random scoreboard bench for imm_extend_unit.
module tb_imm_extend_unit;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        in_valid = 1'b0;
   logic [24:0] src      = '0;
   logic [1:0]  control  = '0;
`ifdef IMM_EXTEND_UTYPE_EN
   logic        utype_sel = 1'b0;
`endif
   logic [31:0] extend_src;
   logic        out_valid;
   logic [31:0] imm_comb;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] last_reg = '0;

   imm_extend_unit dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .src        (src),
      .control    (control),
`ifdef IMM_EXTEND_UTYPE_EN
      .utype_sel  (utype_sel),
`endif
      .extend_src (extend_src),
      .out_valid  (out_valid),
      .imm_comb   (imm_comb)
   );

   always #5 clk = ~clk;

   // Reference immediates written in terms of the full instruction word
   function automatic logic [31:0] ref_imm(input logic [31:0] instr, input logic [1:0] fmt,
                                           input logic u);
      if (u) return {instr[31:12], 12'h000};
      case (fmt)
         2'b00:   return {{20{instr[31]}}, instr[31:20]};
         2'b01:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
         2'b10:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // Drive one cycle at negedge, check comb output, then check registered output after posedge
   task automatic step(input string tag, input logic [31:0] instr, input logic [1:0] fmt,
                       input logic v, input logic u);
      logic [31:0] e;
      logic [31:0] popped;
      logic        ue;
      @(negedge clk);
      in_valid = v;
      src      = instr[31:7];
      control  = fmt;
`ifdef IMM_EXTEND_UTYPE_EN
      utype_sel = u;
      ue        = u;
`else
      ue        = 1'b0;
`endif
      e = ref_imm(instr, fmt, ue);
      #1;
      check({tag, "_comb"}, imm_comb, e);
      if (v) exp_q.push_back(e);
      @(posedge clk);
      #1;
      check({tag, "_valid"}, 32'(out_valid), 32'(v));
      if (v) begin
         if (exp_q.size() == 0) begin
            check({tag, "_underflow"}, extend_src, e);
         end else begin
            popped = exp_q.pop_front();
            check({tag, "_reg"}, extend_src, popped);
            last_reg = popped;
         end
      end else begin
         check({tag, "_hold"}, extend_src, last_reg);
      end
   endtask

   initial begin
      // Reset held across several edges
      repeat (3) @(posedge clk);
      #1;
      check("rst_ext", extend_src, 32'h0000_0000);
      check("rst_vld", 32'(out_valid), 32'h0);
      #1;
      rst_n = 1'b1;
      last_reg = 32'h0;

      step("i_addi", 32'hFFF0_0093, 2'b00, 1'b1, 1'b0);
      check("i_abs", extend_src, 32'hFFFF_FFFF);
      step("s_sw",   32'h0020_A423, 2'b01, 1'b1, 1'b0);
      check("s_abs", extend_src, 32'h0000_0008);
      step("b_beq",  32'hFE00_0EE3, 2'b10, 1'b1, 1'b0);
      check("b_abs", extend_src, 32'hFFFF_FFFC);
      step("j_pos",  32'h0010_006F, 2'b11, 1'b1, 1'b0);
      check("j_pos_abs", extend_src, 32'h0000_0800);
      step("j_neg",  32'h8000_006F, 2'b11, 1'b1, 1'b0);
      check("j_neg_abs", extend_src, 32'hFFF0_0000);

      // Back-to-back I then J, then idle: J value must hold
      step("bb_i",   32'h7FF0_0013, 2'b00, 1'b1, 1'b0);
      step("bb_j",   32'hFFFF_F06F, 2'b11, 1'b1, 1'b0);
      step("idle1",  32'h1234_5678, 2'b01, 1'b0, 1'b0);
      step("idle2",  32'h8765_4321, 2'b10, 1'b0, 1'b0);
      check("hold_abs", extend_src, 32'hFFFF_FFFE);

`ifdef IMM_EXTEND_UTYPE_EN
      step("u_lui",  32'hABCD_E0B7, 2'b10, 1'b1, 1'b1);
      check("u_abs", extend_src, 32'hABCD_E000);
`endif

      for (int i = 0; i < 24; i++) begin
         step("rand", $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 3) == 0));
      end

      // Asynchronous reset between edges while a result is valid
      step("pre_rst", 32'hFFF0_0093, 2'b00, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_ext", extend_src, 32'h0000_0000);
      check("arst_vld", 32'(out_valid), 32'h0);
      exp_q.delete();
      last_reg = 32'h0;
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step("post_idle", 32'h0000_0000, 2'b00, 1'b0, 1'b0);
      step("post_s",    32'hFE11_2E23, 2'b01, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
RV32I immediate generator for the decode stage. It takes instruction bits [31:7] and a 2-bit immediate-format select, and produces the sign-extended 32-bit immediate. The result is registered with one-cycle latency and a valid flag, so it feeds the execute-stage operand mux directly. A combinational copy is also exported for the branch-target adder.

Parameters:
- XLEN, 32, output width; only 32 is supported.
- RESET_IMM, 32'h0000_0000, value loaded into extend_src on reset.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  src/control qualify this cycle.
- src  input  25  instruction bits [31:7]; src[k] = instr[k+7].
- control  input  2  format select: 00 I, 01 S, 10 B, 11 J.
- extend_src  output  32  registered sign-extended immediate.
- out_valid  output  1  extend_src holds the result of the previous valid input.
- imm_comb  output  32  combinational immediate, same formula, no latency.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- While rst_n=0: extend_src=RESET_IMM and out_valid=0. Reset acts immediately and discards any in-flight result. The first valid can be accepted on the first rising edge after rst_n is released.
- Formats, with s = src[24] (instr[31]) as the sign bit:
  - I = {20{s}, src[24:13]}
  - S = {20{s}, src[24:18], src[4:0]}
  - B = {19{s}, src[24], src[0], src[23:18], src[4:1], 1'b0}
  - J = {11{s}, src[24], src[12:5], src[13], src[23:14], 1'b0}
- imm_comb = format(src, control), purely combinational; valid regardless of in_valid.
- On each rising edge with in_valid=1: extend_src <= imm_comb and out_valid <= 1.
- On each rising edge with in_valid=0: extend_src holds its value and out_valid <= 0.
- Latency: exactly 1 cycle. Back-to-back valids give one result per cycle. No backpressure.
- Every control code is legal. X on control when in_valid=1 is a bench error: the assertion fires only in simulation.
- B and J results always have bit 0 = 0.

Optional Feature:
- Macro: IMM_EXTEND_UTYPE_EN.
- Defined: adds input utype_sel (1 bit).
  - When utype_sel=1, it overrides control and the output is U = {src[24:5], 12'b0}. No sign fill is needed.
  - utype_sel applies to both imm_comb and the register path.
- Not defined: the utype_sel port is absent; only I/S/B/J are produced.

Decomposition:
- Package imm_extend_pkg holds:
  - the enum imm_fmt_e (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11);
  - the constant XLEN;
  - a function build_imm(src, fmt) shared with the decoder.
- One sub-module, imm_extend_comb, is the combinational formatter. The top adds the output register, valid flop and assertions.

Test Plan:
- Reset: hold rst_n=0 and toggle clk -> extend_src=0, out_valid=0. Deassert, then in_valid=1 with src=instr[31:7] of 0xFFF00093, control=00 -> next cycle extend_src=0xFFFFFFFF, out_valid=1.
- S-type: instr 0x0020A423 (sw x2,8(x1)), control=01 -> imm_comb=0x00000008 immediately; extend_src=0x00000008 after 1 clk.
- B-type: instr 0xFE000EE3 (beq x0,x0,-4), control=10 -> 0xFFFFFFFC.
- J-type: instr 0x0010006F (jal x0,2048), control=11 -> 0x00000800. Also instr 0x8000006F -> 0xFFF00000.
- Valid/hold: apply two back-to-back valids (I then J), then in_valid=0 -> outputs arrive in order, one per cycle. out_valid drops and extend_src holds the J value.
- Mid-operation reset: assert rst_n asynchronously between edges while out_valid=1 -> extend_src=0 and out_valid=0 immediately, without waiting for a clock edge.
